alu_dispatch: RTL and testbench



---
 rtl/alu_dispatch.sv | 134 +++++++++++++
 tb/tb_alu_dispatch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Issue-side sequencer: decodes one ALU request, launches a single functional unit,
// waits for its done (or a timeout) and returns the result over a valid/ready port.
module alu_dispatch #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] unit_a,
    output logic [N-1:0] unit_b,
    output logic [9:0]   unit_start,
    input  logic [9:0]   unit_done,
    output logic [3:0]   selec_alu,
    input  logic [N-1:0] unit_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [9:0]     start_next;
    logic [3:0]     op_next;
    logic [N-1:0]   a_next, b_next;
    logic           valid_next;
    logic [N-1:0]   result_next;
    logic           err_next;
    logic [15:0]    done_ext;
    logic           done_sel;

    // Only the launched unit's done matters; padding keeps the index in range.
    assign done_ext = {6'b0, unit_done};
    assign done_sel = done_ext[selec_alu];

    assign req_ready = (state == IDLE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            unit_start <= '0;
            selec_alu  <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            unit_start <= start_next;
            selec_alu  <= op_next;
            unit_a     <= a_next;
            unit_b     <= b_next;
            rsp_valid  <= valid_next;
            rsp_result <= result_next;
            rsp_err    <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        start_next  = '0;
        op_next     = selec_alu;
        a_next      = unit_a;
        b_next      = unit_b;
        valid_next  = rsp_valid;
        result_next = rsp_result;
        err_next    = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_next = req_op;
                    a_next  = req_a;
                    b_next  = req_b;
                    if (req_op <= 4'd9) begin
                        state_next = ISSUE;
                        start_next = 10'd1 << req_op;
                    end else begin
                        state_next  = RESP;
                        valid_next  = 1'b1;
                        err_next    = 1'b1;
                        result_next = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // Done takes priority over a timeout landing on the same edge.
                if (done_sel) begin
                    state_next  = RESP;
                    valid_next  = 1'b1;
                    err_next    = 1'b0;
                    result_next = unit_result;
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_next  = RESP;
                    valid_next  = 1'b1;
                    err_next    = 1'b1;
                    result_next = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: linear stimulus with hand-computed expectations,
// each checked by an immediate assertion.
module tb_alu_dispatch;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a, req_b;
    logic [N-1:0] unit_a, unit_b;
    logic [9:0]   unit_start;
    logic [9:0]   unit_done;
    logic [3:0]   selec_alu;
    logic [N-1:0] unit_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_err;

    int vectors = 0;
    int errors  = 0;

    alu_dispatch #(.N(N), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .selec_alu   (selec_alu),
        .unit_result (unit_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = '0;
        req_a       = '0;
        req_b       = '0;
        unit_done   = '0;
        unit_result = '0;
        rsp_ready   = 1'b0;

        tick();
        tick();
        chk("reset_req_ready", 16'(req_ready), 16'h0);
        chk("reset_unit_start", 16'(unit_start), 16'h0);
        chk("reset_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("reset_selec_alu", 16'(selec_alu), 16'h0);
        chk("reset_unit_ab", 16'({unit_a, unit_b}), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("release_req_ready", 16'(req_ready), 16'h1);

        // Single-cycle unit: op 3, done tied high
        rsp_ready   = 1'b1;
        unit_done   = 10'h008;
        unit_result = 4'h7;
        send(4'd3, 4'd5, 4'd2);
        chk("op3_start", 16'(unit_start), 16'h008);
        chk("op3_selec", 16'(selec_alu), 16'h3);
        chk("op3_ab", 16'({unit_a, unit_b}), 16'h52);
        chk("op3_req_ready_e0", 16'(req_ready), 16'h0);
        tick();
        chk("op3_start_e1", 16'(unit_start), 16'h000);
        chk("op3_valid_e1", 16'(rsp_valid), 16'h0);
        tick();
        chk("op3_valid_e2", 16'(rsp_valid), 16'h1);
        chk("op3_result", 16'(rsp_result), 16'h7);
        chk("op3_err", 16'(rsp_err), 16'h0);
        tick();
        chk("op3_valid_e3", 16'(rsp_valid), 16'h0);
        chk("op3_idle_ready", 16'(req_ready), 16'h1);
        chk("op3_selec_hold", 16'(selec_alu), 16'h3);

        // Multi-cycle unit: op 9, done[9] sampled at E7, done[2] noise in WAIT
        unit_done   = '0;
        unit_result = 4'hC;
        send(4'd9, 4'd1, 4'd1);
        chk("op9_start", 16'(unit_start), 16'h200);
        tick();
        unit_done = 10'h004;
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk("op9_no_early_rsp", 16'(rsp_valid), 16'h0);
            chk("op9_start_low", 16'(unit_start), 16'h000);
            unit_done = (i == 6) ? 10'h200 : ((i % 2 == 1) ? 10'h004 : 10'h000);
        end
        tick();
        chk("op9_valid_e7", 16'(rsp_valid), 16'h1);
        chk("op9_result", 16'(rsp_result), 16'hC);
        chk("op9_err", 16'(rsp_err), 16'h0);
        unit_done = '0;
        tick();
        chk("op9_done", 16'(rsp_valid), 16'h0);

        // Illegal op 12
        send(4'd12, 4'd3, 4'd4);
        chk("op12_no_start", 16'(unit_start), 16'h000);
        chk("op12_valid", 16'(rsp_valid), 16'h1);
        chk("op12_err", 16'(rsp_err), 16'h1);
        chk("op12_result", 16'(rsp_result), 16'h0);
        chk("op12_selec", 16'(selec_alu), 16'hC);
        tick();
        chk("op12_no_start_e1", 16'(unit_start), 16'h000);
        chk("op12_valid_e1", 16'(rsp_valid), 16'h0);

        // Timeout: op 1, done never arrives, error after E17
        unit_result = 4'hA;
        send(4'd1, 4'd0, 4'd0);
        chk("to_start", 16'(unit_start), 16'h002);
        for (int i = 1; i <= 16; i++) tick();
        chk("to_no_early_rsp", 16'(rsp_valid), 16'h0);
        tick();
        chk("to_valid_e17", 16'(rsp_valid), 16'h1);
        chk("to_err", 16'(rsp_err), 16'h1);
        chk("to_result", 16'(rsp_result), 16'h0);
        tick();

        // Done arriving on the timeout edge wins
        send(4'd1, 4'd0, 4'd0);
        for (int i = 1; i <= 16; i++) tick();
        chk("to2_no_early_rsp", 16'(rsp_valid), 16'h0);
        unit_done = 10'h002;
        tick();
        chk("to2_valid_e17", 16'(rsp_valid), 16'h1);
        chk("to2_err", 16'(rsp_err), 16'h0);
        chk("to2_result", 16'(rsp_result), 16'hA);
        tick();
        chk("to2_idle", 16'(req_ready), 16'h1);

        // Backpressure: rsp_ready low for 6 cycles, new request held off
        rsp_ready   = 1'b0;
        unit_done   = 10'h3FF;
        unit_result = 4'h5;
        send(4'd0, 4'd2, 4'd3);
        tick();
        tick();
        chk("bp_valid", 16'(rsp_valid), 16'h1);
        req_valid   = 1'b1;
        req_op      = 4'd4;
        req_a       = 4'd8;
        req_b       = 4'd9;
        unit_result = 4'hE;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid_hold", 16'(rsp_valid), 16'h1);
            chk("bp_result_hold", 16'(rsp_result), 16'h5);
            chk("bp_err_hold", 16'(rsp_err), 16'h0);
            chk("bp_req_ready", 16'(req_ready), 16'h0);
            chk("bp_no_start", 16'(unit_start), 16'h000);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 16'(rsp_valid), 16'h0);
        chk("bp_release_no_start", 16'(unit_start), 16'h000);
        chk("bp_release_selec", 16'(selec_alu), 16'h0);
        chk("bp_release_ready", 16'(req_ready), 16'h1);
        tick();
        req_valid = 1'b0;
        chk("bp_accept_start", 16'(unit_start), 16'h010);
        chk("bp_accept_selec", 16'(selec_alu), 16'h4);
        chk("bp_accept_ab", 16'({unit_a, unit_b}), 16'h89);
        tick();
        tick();
        chk("bp_op4_valid", 16'(rsp_valid), 16'h1);
        chk("bp_op4_result", 16'(rsp_result), 16'hE);
        tick();

        // Reset during WAIT of op 6; late done must be ignored
        unit_done = '0;
        send(4'd6, 4'd3, 4'd9);
        chk("rst_op6_start", 16'(unit_start), 16'h040);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready_low", 16'(req_ready), 16'h0);
        tick();
        chk("rst_outputs_zero", 16'({unit_start, rsp_valid, rsp_err}), 16'h0);
        chk("rst_regs_zero", 16'({selec_alu, unit_a, unit_b, rsp_result}), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 16'(req_ready), 16'h1);
        unit_done   = 10'h040;
        unit_result = 4'h9;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_late_done_ignored", 16'(rsp_valid), 16'h0);
            chk("rst_still_idle", 16'(req_ready), 16'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
